// File: rtl/bw_round_engine_if.sv
// bw_round_engine_if: player handshakes, hand/score status and round results for bw_round_engine.
interface bw_round_engine_if #(parameter int NCARD = 9);
  localparam int CIW = $clog2(NCARD);
  localparam int CW = $clog2(NCARD + 1);
  logic start;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [CIW-1:0] a_card, b_card;
  logic [NCARD-1:0] a_hand, b_hand;
  logic [CW-1:0] a_black, a_white, b_black, b_white;
  logic res_valid;
  logic [1:0] res_winner;
  logic [CW-1:0] a_score, b_score, round;
  logic game_over, err;
  modport master(
    output start, a_valid, a_card, b_valid, b_card,
    input a_ready, b_ready, a_hand, b_hand, a_black, a_white, b_black, b_white,
    input res_valid, res_winner, a_score, b_score, round, game_over, err
  );
  modport slave(
    input start, a_valid, a_card, b_valid, b_card,
    output a_ready, b_ready, a_hand, b_hand, a_black, a_white, b_black, b_white,
    output res_valid, res_winner, a_score, b_score, round, game_over, err
  );
endinterface

// File: rtl/bw_round_engine.sv
// bw_round_engine: two-player tile duel; each round both players play one tile and the higher value wins.
module bw_round_engine #(
  parameter int NCARD = 9
) (
  input logic clk,
  input logic reset,
  bw_round_engine_if.slave bus
);
  localparam int CIW = $clog2(NCARD);
  localparam int CW = $clog2(NCARD + 1);
  typedef enum logic [1:0] {IDLE, PLAY, RESOLVE, DONE} state_t;
  state_t state, state_next;
  logic [NCARD-1:0] a_hand, b_hand;
  logic a_lat, b_lat;
  logic [CIW-1:0] a_idx, b_idx, a_val, b_val;
  logic [CW-1:0] a_score, b_score, round;
  logic [CW-1:0] a_black, a_white, b_black, b_white;
  logic [1:0] winner;
  logic err;
  logic a_ready, b_ready, a_ok, b_ok, a_bad, b_bad, settle;
  assign a_ready = state == PLAY && !a_lat;
  assign b_ready = state == PLAY && !b_lat;
  assign a_ok = bus.a_valid && a_ready && int'(bus.a_card) < NCARD && a_hand[bus.a_card];
  assign b_ok = bus.b_valid && b_ready && int'(bus.b_card) < NCARD && b_hand[bus.b_card];
  assign a_bad = bus.a_valid && a_ready && !a_ok;
  assign b_bad = bus.b_valid && b_ready && !b_ok;
  assign a_val = a_lat ? a_idx : bus.a_card;
  assign b_val = b_lat ? b_idx : bus.b_card;
  // A round settles on the edge that supplies the second tile, whether it was latched earlier or arrives now
  assign settle = state == PLAY && (a_lat || a_ok) && (b_lat || b_ok);
  always_comb begin
    state_next = bus.start ? PLAY :
                 settle ? RESOLVE :
                 state == RESOLVE ? (round == CW'(NCARD) ? DONE : PLAY) : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_hand <= '0;
      b_hand <= '0;
      a_lat <= 1'b0;
      b_lat <= 1'b0;
      a_idx <= '0;
      b_idx <= '0;
      a_score <= '0;
      b_score <= '0;
      round <= '0;
      winner <= 2'b00;
      err <= 1'b0;
    end else if (bus.start) begin
      a_hand <= '1;
      b_hand <= '1;
      a_lat <= 1'b0;
      b_lat <= 1'b0;
      a_score <= '0;
      b_score <= '0;
      round <= '0;
      winner <= 2'b00;
      err <= 1'b0;
    end else begin
      err <= a_bad || b_bad;
      if (settle) begin
        a_hand <= a_hand & ~(NCARD'(1) << a_val);
        b_hand <= b_hand & ~(NCARD'(1) << b_val);
        a_lat <= 1'b0;
        b_lat <= 1'b0;
        a_score <= a_score + CW'(a_val > b_val);
        b_score <= b_score + CW'(b_val > a_val);
        round <= round + CW'(1);
        winner <= {b_val > a_val, a_val > b_val};
      end else begin
        if (a_ok) begin
          a_lat <= 1'b1;
          a_idx <= bus.a_card;
        end
        if (b_ok) begin
          b_lat <= 1'b1;
          b_idx <= bus.b_card;
        end
      end
    end
  end
  // Odd bit indices hold even tile values (black), even indices hold odd values (white)
  always_comb begin
    a_black = '0;
    a_white = '0;
    b_black = '0;
    b_white = '0;
    for (int i = 1; i < NCARD; i += 2) begin
      a_black = a_black + CW'(a_hand[i]);
      b_black = b_black + CW'(b_hand[i]);
    end
    for (int i = 0; i < NCARD; i += 2) begin
      a_white = a_white + CW'(a_hand[i]);
      b_white = b_white + CW'(b_hand[i]);
    end
  end
  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;
  assign bus.a_hand = a_hand;
  assign bus.b_hand = b_hand;
  assign bus.a_black = a_black;
  assign bus.a_white = a_white;
  assign bus.b_black = b_black;
  assign bus.b_white = b_white;
  assign bus.res_valid = state == RESOLVE;
  assign bus.res_winner = winner;
  assign bus.a_score = a_score;
  assign bus.b_score = b_score;
  assign bus.round = round;
  assign bus.game_over = state == DONE;
  assign bus.err = err;
endmodule

// File: doc/bw_round_engine.md
BW_ROUND_ENGINE -- requirements
Module: bw_round_engine

Interface
REQ-001 SHALL have parameter NCARD, default 9, giving the tiles per player (values 1..NCARD, legal range 2..31).
REQ-002 SHALL have derived localparams CIW = clog2(NCARD) (tile index width) and CW = clog2(NCARD+1) (count width).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new game; one-cycle pulse.
- a_valid  in  1  player A offers a tile.
- a_card  in  CIW  A tile index; index i is tile value i+1.
- a_ready  out  1  A tile accepted when a_valid&a_ready.
- b_valid, b_card, b_ready  same as the a_* ports, for player B.
- a_hand, b_hand  out  NCARD  remaining-tile masks; bit i is tile value i+1.
- a_black, a_white, b_black, b_white  out  CW  remaining even-valued (black) and odd-valued (white) tile counts.
- res_valid  out  1  round-result strobe.
- res_winner  out  2  01 = A, 10 = B, 00 = tie; held between strobes.
- a_score, b_score  out  CW  rounds won.
- round  out  CW  rounds resolved.
- game_over  out  1  all rounds played.
- err  out  1  illegal-tile pulse.

Function
REQ-004 SHALL implement the FSM IDLE -> PLAY -> RESOLVE -> (PLAY | DONE), with start from any state going to PLAY.
REQ-005 SHALL, on start (any state, not in reset), on the next edge:
- load a_hand and b_hand with all ones;
- clear scores, round, res_winner, any latched tiles;
- enter PLAY.
REQ-006 SHALL drive a_ready high only in PLAY while no A tile is latched for the current round; b_ready follows the same rule for B.
REQ-007 SHALL treat a handshake (valid&ready) as legal only if the index is < NCARD and the tile's bit in that player's hand is 1; on a legal handshake it latches the index.
REQ-008 SHALL, on an illegal handshake:
- not latch the tile;
- keep ready high;
- pulse err for exactly one cycle, the cycle after the handshake.
REQ-009 SHALL allow A and B handshakes in the same cycle or in any order; each player's latch is independent.
REQ-010 SHALL, on the edge that completes the second legal latch of a round:
- clear both played bits from the hands;
- increment the winner's score (higher tile value wins; equal values tie, no score change);
- increment round;
- set res_winner;
- enter RESOLVE.
REQ-011 SHALL assert res_valid for exactly the single RESOLVE cycle, with hands, counts, scores and round already updated in that cycle; a_ready and b_ready are 0 in RESOLVE.
REQ-012 SHALL leave RESOLVE to DONE if round == NCARD, else to PLAY, with latches cleared.
REQ-013 SHALL hold game_over = 1 in DONE, with both ready signals 0, until start or reset.
REQ-014 SHALL compute the black/white counts as the popcount of the hand over odd bit indices (even values) and even bit indices (odd values) respectively, consistent with the hand in the same cycle.
REQ-015 SHALL ignore valid inputs in IDLE, RESOLVE and DONE, with no err pulse.
REQ-016 SHALL give start priority over a simultaneous handshake; the handshake is discarded.

Reset
REQ-017 SHALL, while reset = 1, on the edge:
- enter IDLE;
- clear hands, counts, scores, round, res_winner, latches, res_valid, err and game_over;
- have all outputs 0 the following cycle.
REQ-018 SHALL give reset priority over start and handshakes, including mid-round with one tile latched; that latch is lost.

Verification (NCARD=9)
REQ-019 SHALL cover reset and start:
- reset held 2 cycles -> all outputs 0, a_ready = b_ready = 0;
- start -> next cycle a_hand = b_hand = 1FF, a_black = 4, a_white = 5, both ready = 1, round = 0.
REQ-020 SHALL cover an A win: A plays idx 8 at cycle t, B plays idx 1 at t+2 ->
- t+3: res_valid = 1, res_winner = 01, a_score = 1;
- a_hand = 0FF, a_white = 4;
- b_hand = 1FD, b_black = 3;
- round = 1, readies 0;
- t+4: PLAY, readies 1.
REQ-021 SHALL cover a tie: both play idx 4 in the same cycle -> next cycle res_winner = 00, scores unchanged, bit 4 cleared in both hands.
REQ-022 SHALL cover an illegal tile: after REQ-020, A replays idx 8 -> err = 1 for one cycle, a_hand unchanged, a_ready stays 1; index 12 also raises err.
REQ-023 SHALL cover a full game: 9 legal rounds -> after the 9th RESOLVE, game_over = 1, round = 9, hands 000, scores sum to 9 minus the tie count; start then re-enters PLAY with full hands.
REQ-024 SHALL cover reset mid-game: reset asserted with only A latched in round 3 -> next cycle IDLE with all outputs 0; a following start begins at round 0.
